// File: rtl/button_counter_mux.sv
// Debounced push-button counter (hex or BCD, DIGITS nibbles) driving a multiplexed common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining BCNT_LZ_BLANK_EN.
module button_counter_mux #(
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REFRESH_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_inc,
    input  logic                  btn_clr,
    input  logic                  dec_mode,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned CNT_W = 4 * DIGITS;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned REF_W = $clog2(REFRESH_CYCLES);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic              r_inc_s1, r_inc_s2;
    logic              r_clr_s1, r_clr_s2;
    logic              r_mode_s1, r_mode_s2, r_mode_d;
    logic              r_db_level;
    logic [DB_W-1:0]   r_db_cnt;
    logic [CNT_W-1:0]  r_count;
    logic              r_wrap;
    logic [REF_W-1:0]  r_ref_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_an;

    logic              w_db_diff;
    logic              w_db_done;
    logic              w_inc_pulse;
    logic              w_mode_edge;
    logic [3:0]        w_lim;
    logic [CNT_W-1:0]  w_count_inc;
    logic              w_carry;
    logic [3:0]        w_nib;
    logic [DIGITS-1:0] w_an;
    logic [DIGITS-1:0] w_blank;
    logic              w_blank_cur;
    logic [6:0]        w_seg;

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Two-flop synchronisers for all asynchronous inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inc_s1  <= 1'b0;
            r_inc_s2  <= 1'b0;
            r_clr_s1  <= 1'b0;
            r_clr_s2  <= 1'b0;
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
            r_mode_d  <= 1'b0;
        end else begin
            r_inc_s1  <= btn_inc;
            r_inc_s2  <= r_inc_s1;
            r_clr_s1  <= btn_clr;
            r_clr_s2  <= r_clr_s1;
            r_mode_s1 <= dec_mode;
            r_mode_s2 <= r_mode_s1;
            r_mode_d  <= r_mode_s2;
        end
    end

    assign w_db_diff   = r_inc_s2 ^ r_db_level;
    assign w_db_done   = w_db_diff && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign w_inc_pulse = w_db_done && r_inc_s2;
    assign w_mode_edge = r_mode_s2 ^ r_mode_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
        end else if (!w_db_diff) begin
            r_db_cnt   <= '0;
        end else if (w_db_done) begin
            r_db_level <= r_inc_s2;
            r_db_cnt   <= '0;
        end else begin
            r_db_cnt   <= r_db_cnt + 1'b1;
        end
    end

    // Ripple increment: each nibble wraps at its limit and carries onward in the same cycle
    assign w_lim = r_mode_s2 ? 4'h9 : 4'hF;

    always_comb begin
        w_count_inc = r_count;
        w_carry     = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (w_carry) begin
                if (r_count[4*k +: 4] == w_lim) begin
                    w_count_inc[4*k +: 4] = 4'h0;
                end else begin
                    w_count_inc[4*k +: 4] = r_count[4*k +: 4] + 4'h1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (r_clr_s2 || w_mode_edge) begin
                r_count <= '0;
            end else if (w_inc_pulse) begin
                r_count <= w_count_inc;
                r_wrap  <= (w_count_inc == '0);
            end
        end
    end

`ifdef BCNT_LZ_BLANK_EN
    // A digit is blank when it and every more significant nibble are zero; digit 0 always shows
    always_comb begin
        logic w_lead;
        w_blank = '0;
        w_lead  = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            w_lead     = w_lead && (r_count[4*k +: 4] == 4'h0);
            w_blank[k] = w_lead;
        end
    end
`else
    assign w_blank = '0;
`endif

    always_comb begin
        w_nib       = 4'h0;
        w_an        = '1;
        w_blank_cur = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (IDX_W'(k) == r_idx) begin
                w_nib       = r_count[4*k +: 4];
                w_an[k]     = 1'b0;
                w_blank_cur = w_blank[k];
            end
        end
        w_seg = w_blank_cur ? 7'h7F : f_glyph(w_nib);
    end

    // Refresh timer, digit index and registered display pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ref_cnt <= '0;
            r_idx     <= '0;
            r_seg     <= 7'h7F;
            r_an      <= '1;
        end else begin
            r_seg <= w_seg;
            r_an  <= w_an;
            if (r_ref_cnt == REF_W'(REFRESH_CYCLES - 1)) begin
                r_ref_cnt <= '0;
                r_idx     <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_ref_cnt <= r_ref_cnt + 1'b1;
            end
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign seg   = r_seg;
    assign an    = r_an;

endmodule

// File: tb/tb_button_counter_mux.sv
// Scoreboard bench for button_counter_mux (DIGITS=2, DEBOUNCE_CYCLES=4, REFRESH_CYCLES=4).
module tb_button_counter_mux;

    localparam int unsigned DIGITS = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  btn_inc;
    logic                  btn_clr;
    logic                  dec_mode;
    logic [4*DIGITS-1:0]   count;
    logic                  wrap;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;

    typedef struct {
        logic [7:0] cnt;
        logic       wrp;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         fails  = 0;
    logic       mon_en = 1'b0;
    logic       bcd_mode = 1'b0;
    logic [7:0] prev_count;

    button_counter_mux #(
        .DIGITS         (DIGITS),
        .DEBOUNCE_CYCLES(4),
        .REFRESH_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_inc (btn_inc),
        .btn_clr (btn_clr),
        .dec_mode(dec_mode),
        .count   (count),
        .wrap    (wrap),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] c, input logic w);
        exp_t e;
        e.cnt = c;
        e.wrp = w;
        q.push_back(e);
    endtask

    function automatic logic [7:0] bcd(input int n);
        return 8'(((n / 10) % 10) * 16 + (n % 10));
    endfunction

    task automatic press();
        btn_inc = 1'b1;
        repeat (6) @(negedge clk);
        btn_inc = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Monitor: every count change must match the next scoreboard entry; wrap must be quiet otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            if (count !== prev_count) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected count change: got %0h, none pending", count);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("count", 32'(count), 32'(e.cnt));
                    check("wrap on change", 32'(wrap), 32'(e.wrp));
                    if (bcd_mode)
                        check("bcd nibbles <= 9", 32'((count[7:4] <= 4'd9) && (count[3:0] <= 4'd9)), 32'd1);
                end
                prev_count = count;
            end else begin
                check("wrap idle", 32'(wrap), 32'd0);
            end
        end
    end

    initial begin
        logic [1:0] first_an;
        logic [1:0] exp_an;
        logic [6:0] exp_seg;
        logic       changed;

        rst_n    = 1'b0;
        btn_inc  = 1'b1;
        btn_clr  = 1'b0;
        dec_mode = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check("reset count", 32'(count), 32'h0);
            check("reset wrap", 32'(wrap), 32'h0);
            check("reset seg", 32'(seg), 32'h7F);
            check("reset an", 32'(an), 32'h3);
        end
        rst_n   = 1'b1;
        btn_inc = 1'b0;
        @(negedge clk);
        check("post-reset an", 32'(an), 32'h2);
        check("post-reset seg", 32'(seg), 32'h40);
        prev_count = count;
        mon_en     = 1'b1;

        // Debounce: short glitch rejected, long hold counts once
        btn_inc = 1'b1;
        repeat (3) @(negedge clk);
        btn_inc = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch ignored", 32'(count), 32'h00);
        push_exp(8'h01, 1'b0);
        btn_inc = 1'b1;
        repeat (10) @(negedge clk);
        check("held press once", 32'(count), 32'h01);
        btn_inc = 1'b0;
        repeat (8) @(negedge clk);
        check("release no count", 32'(count), 32'h01);

        // Hex wrap
        for (int i = 2; i <= 255; i++) begin
            push_exp(8'(i), 1'b0);
            press();
        end
        check("hex 0xFF", 32'(count), 32'hFF);
        push_exp(8'h00, 1'b1);
        press();
        check("hex wrap to 0", 32'(count), 32'h00);

        // BCD carry and wrap
        dec_mode = 1'b1;
        bcd_mode = 1'b1;
        repeat (4) @(negedge clk);
        for (int n = 1; n <= 9; n++) begin
            push_exp(bcd(n), 1'b0);
            press();
        end
        check("bcd 09", 32'(count), 32'h09);
        push_exp(bcd(10), 1'b0);
        press();
        check("bcd 10", 32'(count), 32'h10);
        for (int n = 11; n <= 99; n++) begin
            push_exp(bcd(n), 1'b0);
            press();
        end
        check("bcd 99", 32'(count), 32'h99);
        push_exp(8'h00, 1'b1);
        press();
        check("bcd wrap to 0", 32'(count), 32'h00);

        // Clear wins over a simultaneous debounced press
        for (int n = 1; n <= 37; n++) begin
            push_exp(bcd(n), 1'b0);
            press();
        end
        check("bcd 37", 32'(count), 32'h37);
        push_exp(8'h00, 1'b0);
        btn_inc = 1'b1;
        btn_clr = 1'b1;
        repeat (6) @(negedge clk);
        btn_inc = 1'b0;
        repeat (2) @(negedge clk);
        btn_clr = 1'b0;
        repeat (8) @(negedge clk);
        check("clear beats press", 32'(count), 32'h00);

        // Mode change clears
        for (int n = 1; n <= 5; n++) begin
            push_exp(bcd(n), 1'b0);
            press();
        end
        check("bcd 05", 32'(count), 32'h05);
        push_exp(8'h00, 1'b0);
        dec_mode = 1'b0;
        bcd_mode = 1'b0;
        repeat (6) @(negedge clk);
        check("mode change clears", 32'(count), 32'h00);

        // Display multiplexing at count 0x05
        for (int n = 1; n <= 5; n++) begin
            push_exp(8'(n), 1'b0);
            press();
        end
        check("hex 05", 32'(count), 32'h05);
        first_an = an;
        changed  = 1'b0;
        for (int t = 0; t < 10 && !changed; t++) begin
            @(negedge clk);
            if (an != first_an) changed = 1'b1;
        end
        check("an toggles", 32'(changed), 32'd1);
        first_an = an;
        check("an one-hot-cold", 32'((first_an == 2'b10) || (first_an == 2'b01)), 32'd1);
        for (int i = 0; i < 16; i++) begin
            exp_an = (((i / 4) % 2) == 0) ? first_an : ~first_an;
`ifdef BCNT_LZ_BLANK_EN
            exp_seg = (exp_an == 2'b10) ? 7'h12 : 7'h7F;
`else
            exp_seg = (exp_an == 2'b10) ? 7'h12 : 7'h40;
`endif
            check("mux an", 32'(an), 32'(exp_an));
            check("mux seg", 32'(seg), 32'(exp_seg));
            @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("scoreboard drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
